tcp_rx_wrk_pd_arb: RTL

- Packet-atomic round-robin scheduler that merges REQ_NUM worker packet-descriptor streams into one TCP RX descriptor output.
- Each descriptor is PDSZ consecutive cells of PDWID bits.
- Inserts a configurable idle gap between granted packets.
- Sits downstream of the per-flow worker ctrl stage and upstream of the RX table lookup.

---
 rtl/tcp_rx_wrk_pd_arb_pkg.sv | 22 ++
 rtl/tcp_rx_rr_pick.sv | 32 +++
 rtl/tcp_rx_wrk_pd_arb.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tcp_rx_wrk_pd_arb_pkg.sv
// Shared types and constants for the TCP RX worker descriptor arbiter.
// Debug field offsets apply when TCP_RX_WRK_PD_ARB_STAT_EN is defined.
package tcp_rx_wrk_pd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // dbg_sig layout: {pkt_cnt[15:0], stall_cnt[7:0], state[1:0], 2'b0, gnt[3:0]}
  localparam int DBG_GNT_LSB   = 0;
  localparam int DBG_STATE_LSB = 6;
  localparam int DBG_STALL_LSB = 8;
  localparam int DBG_PKT_LSB   = 16;
  localparam int DBG_FULL_W    = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcp_rx_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_ptr,
// wrapping modulo REQ_NUM.
module tcp_rx_rr_pick
  import tcp_rx_wrk_pd_arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int IDX_W   = idx_w(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic               any_req,
  output logic [IDX_W-1:0]   pick
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    idx   = last_ptr;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = (idx == IDX_W'(REQ_NUM - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/tcp_rx_wrk_pd_arb.sv
// Packet-atomic round-robin merge of REQ_NUM worker descriptor streams.
// Optional counters in dbg_sig: define TCP_RX_WRK_PD_ARB_STAT_EN.
module tcp_rx_wrk_pd_arb
  import tcp_rx_wrk_pd_arb_pkg::*;
#(
  parameter int PDWID   = 128,
  parameter int PDSZ    = 4,
  parameter int REQ_NUM = 4,
  parameter int GAP_WID = 16,
  parameter int DBG_WID = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flag_toe_exit,
  input  logic [GAP_WID-1:0]       cfg_cell_gap,
  input  logic [REQ_NUM-1:0]       in_pd_vld,
  input  logic [REQ_NUM*PDWID-1:0] in_pd_dat,
  output logic [REQ_NUM-1:0]       in_pd_rdy,
  output logic                     out_pd_vld,
  output logic [PDWID-1:0]         out_pd_dat,
  input  logic                     out_pd_rdy,
  output logic [DBG_WID-1:0]       dbg_sig
);

  localparam int GNT_W = idx_w(REQ_NUM);
  localparam int CNT_W = idx_w(PDSZ);

  // Valid/ready: a cell moves when vld && rdy; in XFER the granted requester is
  // wired straight through to the output with zero latency.
  arb_state_e         state, state_nxt;
  logic [GNT_W-1:0]   gnt, gnt_nxt, last_ptr, last_ptr_nxt, pick;
  logic [CNT_W-1:0]   cell_cnt, cell_cnt_nxt;
  logic [GAP_WID-1:0] gap_cnt, gap_cnt_nxt;
  logic               any_req, sel_vld, fire, last_cell;
  logic [PDWID-1:0]   sel_dat;

  tcp_rx_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (GNT_W)
  ) u_pick (
    .req      (in_pd_vld),
    .last_ptr (last_ptr),
    .any_req  (any_req),
    .pick     (pick)
  );

  always_comb begin
    sel_vld   = 1'b0;
    sel_dat   = '0;
    in_pd_rdy = '0;
    for (int j = 0; j < REQ_NUM; j++) begin
      if (gnt == GNT_W'(j)) begin
        sel_vld = in_pd_vld[j];
        sel_dat = in_pd_dat[j*PDWID +: PDWID];
        if (state == XFER) in_pd_rdy[j] = out_pd_rdy;
      end
    end
  end

  assign out_pd_vld = (state == XFER) && sel_vld;
  assign out_pd_dat = (state == XFER) ? sel_dat : '0;
  assign fire       = out_pd_vld && out_pd_rdy;
  assign last_cell  = fire && (cell_cnt == CNT_W'(PDSZ - 1));

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_ptr_nxt = last_ptr;
    cell_cnt_nxt = cell_cnt;
    gap_cnt_nxt  = gap_cnt;
    case (state)
      IDLE: begin
        if (any_req && !flag_toe_exit) begin
          gnt_nxt   = pick;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (last_cell) begin
          cell_cnt_nxt = '0;
          last_ptr_nxt = gnt;
          if (cfg_cell_gap != '0) begin
            gap_cnt_nxt = cfg_cell_gap;
            state_nxt   = GAP;
          end else begin
            state_nxt = IDLE;
          end
        end else if (fire) begin
          cell_cnt_nxt = cell_cnt + 1'b1;
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt - 1'b1;
        if (gap_cnt == GAP_WID'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      last_ptr <= GNT_W'(REQ_NUM - 1);
      cell_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_ptr <= last_ptr_nxt;
      cell_cnt <= cell_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
    end
  end

`ifdef TCP_RX_WRK_PD_ARB_STAT_EN
  logic [15:0]           pkt_cnt;
  logic [7:0]            stall_cnt;
  logic [DBG_FULL_W-1:0] dbg_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (last_cell) pkt_cnt <= pkt_cnt + 1'b1;
      if ((state == XFER) && !sel_vld && (stall_cnt != 8'hFF))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    dbg_full                         = '0;
    dbg_full[DBG_PKT_LSB +: 16]      = pkt_cnt;
    dbg_full[DBG_STALL_LSB +: 8]     = stall_cnt;
    dbg_full[DBG_STATE_LSB +: 2]     = state;
    dbg_full[DBG_GNT_LSB +: 4]       = 4'(gnt);
  end

  assign dbg_sig = DBG_WID'(dbg_full);
`else
  assign dbg_sig = '0;
`endif

endmodule
